result_collector: RTL

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 118 +++++++++++
 1 files changed

// File: rtl/result_collector.sv
// Collects a 128-bit AES or 512-bit Keccak result and drains it as 32-bit words, LSW first.
// Optional macro RESULT_COLLECTOR_BYTESWAP_EN reverses byte order within each output word.
module result_collector (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_aes_or_keccak,
    input  logic         i_done,
    input  logic [511:0] i_result,
    input  logic         i_ready,
    input  logic         i_clr_err,
    output logic [31:0]  o_word,
    output logic         o_valid,
    output logic         o_last,
    output logic [4:0]   o_remaining,
    output logic         o_busy,
    output logic         o_overrun
);

    localparam logic [4:0] AES_WORDS    = 5'd4;
    localparam logic [4:0] KECCAK_WORDS = 5'd16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [511:0] r_buf;
    logic [4:0]   r_remaining;
    logic         r_overrun;

    logic         w_xfer;
    logic         w_last;
    logic         w_last_xfer;
    logic         w_capture;
    logic         w_drop;
    logic [511:0] w_load;

`ifdef RESULT_COLLECTOR_BYTESWAP_EN
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
`endif

    assign w_xfer      = (r_state == DRAIN) && i_ready;
    assign w_last      = (r_state == DRAIN) && (r_remaining == 5'd1);
    assign w_last_xfer = w_xfer && w_last;

    // A new result is accepted when idle, or exactly as the final word leaves.
    assign w_capture = i_done && ((r_state == IDLE) || w_last_xfer);
    assign w_drop    = i_done && (r_state == DRAIN) && !w_last_xfer;

    // Upper bits are cleared for AES so the buffer drains to zero after its 4 words.
    assign w_load = i_aes_or_keccak ? {384'b0, i_result[127:0]} : i_result;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_done) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_xfer) begin
                    w_next_state = i_done ? DRAIN : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_buf       <= '0;
            r_remaining <= '0;
        end else if (w_capture) begin
            r_buf       <= w_load;
            r_remaining <= i_aes_or_keccak ? AES_WORDS : KECCAK_WORDS;
        end else if (w_xfer) begin
            r_buf       <= {32'b0, r_buf[511:32]};
            r_remaining <= r_remaining - 5'd1;
        end
    end

    // Set has priority over clear so a simultaneous drop is never lost.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_clr_err) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef RESULT_COLLECTOR_BYTESWAP_EN
    assign o_word = byte_swap(r_buf[31:0]);
`else
    assign o_word = r_buf[31:0];
`endif

    assign o_valid     = (r_state == DRAIN);
    assign o_busy      = (r_state == DRAIN);
    assign o_last      = w_last;
    assign o_remaining = r_remaining;
    assign o_overrun   = r_overrun;

endmodule
